// File: rtl/bop_multi_tracker.sv
// Multi-stream consecutive-access run tracker with a circular overflow-region table.
// Define BOP_REGION_MERGE_EN to coalesce a region that starts where the last one ended.
module bop_multi_tracker #(
    parameter int ADDR_W        = 32,
    parameter int NUM_TRACKERS  = 2,
    parameter int REGION_DEPTH  = 8,
    parameter int TIMEOUT       = 10,
    parameter int MIN_RUN_BYTES = 4,
    parameter int EXCL_REG0     = 2,
    parameter int EXCL_REG1     = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              en_i,
    input  logic                              instr_valid_i,
    input  logic [ADDR_W-1:0]                 pc_i,
    input  logic                              is_load_i,
    input  logic                              is_store_i,
    input  logic                              is_jalr_i,
    input  logic [1:0]                        size_i,
    input  logic [ADDR_W-1:0]                 base_i,
    input  logic [ADDR_W-1:0]                 imm_i,
    input  logic [4:0]                        rs1_i,
    input  logic [4:0]                        rd_i,
    input  logic                              clear_i,
    output logic                              region_wr_o,
    output logic                              load_hit_o,
    output logic                              chain_alarm_o,
    output logic                              leak_alarm_o,
    output logic [$clog2(REGION_DEPTH+1)-1:0] region_count_o
);

    localparam int CNT_W = $clog2(REGION_DEPTH + 1);
    localparam int PTR_W = (REGION_DEPTH > 1) ? $clog2(REGION_DEPTH) : 1;
    localparam int TRK_W = (NUM_TRACKERS > 1) ? $clog2(NUM_TRACKERS) : 1;
    localparam logic [3:0]  TMO      = 4'(TIMEOUT);
    localparam logic [31:0] MIN_RUN  = 32'(MIN_RUN_BYTES);
    localparam logic [4:0]  EXCL0    = 5'(EXCL_REG0);
    localparam logic [4:0]  EXCL1    = 5'(EXCL_REG1);

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [2:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? '1 : s[31:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(REGION_DEPTH)) ? c : c + CNT_W'(1);
    endfunction

    // Tracker state
    logic [NUM_TRACKERS-1:0] trk_act_q, trk_ld_q;
    logic [ADDR_W-1:0]       trk_start_q [NUM_TRACKERS];
    logic [ADDR_W-1:0]       trk_nxt_q   [NUM_TRACKERS];
    logic [31:0]             trk_count_q [NUM_TRACKERS];
    logic [3:0]              trk_date_q  [NUM_TRACKERS];

    // Region table state
    logic [REGION_DEPTH-1:0] rgn_vld_q;
    logic [ADDR_W-1:0]       rgn_start_q [REGION_DEPTH];
    logic [ADDR_W-1:0]       rgn_end_q   [REGION_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [CNT_W-1:0]        rgn_cnt_q;

    logic [ADDR_W-1:0] last_pc_q;
    logic [4:0]        last_hit_rd_q;
    logic              last_hit_vld_q;

    // Combinational decode
    logic                    ni, trk_op, op_ld, ext, alloc, evict;
    logic [ADDR_W-1:0]       addr;
    logic [2:0]              op_bytes;
    logic                    match_hit, free_hit, exp_hit;
    logic [TRK_W-1:0]        match_idx, free_idx, evict_idx, exp_idx, sel_idx;
    logic [3:0]              min_date;
    logic                    wr_en, merge_en;
    logic [ADDR_W-1:0]       wr_start, wr_end;
    logic [PTR_W-1:0]        last_ptr;
    logic                    rgn_hit, rgn_start_hit;
    logic [NUM_TRACKERS-1:0] close_mask, alloc_mask, trk_act_d, trk_ld_d;

    always_comb begin
        ni     = instr_valid_i & en_i & (pc_i != last_pc_q);
        addr   = base_i + imm_i;
        op_ld  = is_load_i;
        trk_op = ni & (is_load_i | is_store_i) & (rs1_i != EXCL0) & (rs1_i != EXCL1);
        case (size_i)
            2'd0:    op_bytes = 3'd1;
            2'd1:    op_bytes = 3'd2;
            default: op_bytes = 3'd4;
        endcase

        // Lowest index wins: scan high to low so the last write is the lowest.
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        exp_hit   = 1'b0;
        exp_idx   = '0;
        for (int i = NUM_TRACKERS - 1; i >= 0; i--) begin
            if (trk_act_q[i] && (trk_ld_q[i] == op_ld) && (trk_nxt_q[i] == addr)
                && (trk_date_q[i] != 4'd0)) begin
                match_hit = 1'b1;
                match_idx = TRK_W'(i);
            end
            if (!trk_act_q[i]) begin
                free_hit = 1'b1;
                free_idx = TRK_W'(i);
            end
            if (trk_act_q[i] && !trk_ld_q[i] && (trk_date_q[i] == 4'd0)) begin
                exp_hit = 1'b1;
                exp_idx = TRK_W'(i);
            end
        end

        evict_idx = '0;
        min_date  = trk_date_q[0];
        for (int i = 1; i < NUM_TRACKERS; i++) begin
            if (trk_date_q[i] < min_date) begin
                min_date  = trk_date_q[i];
                evict_idx = TRK_W'(i);
            end
        end

        ext     = trk_op & match_hit;
        alloc   = trk_op & ~match_hit;
        evict   = alloc & ~free_hit;
        sel_idx = free_hit ? free_idx : evict_idx;

        // Eviction owns the single table write port; expiry closes only otherwise.
        wr_en    = 1'b0;
        wr_start = trk_start_q[exp_idx];
        wr_end   = trk_nxt_q[exp_idx];
        if (evict) begin
            wr_en    = !trk_ld_q[evict_idx] && (trk_count_q[evict_idx] >= MIN_RUN);
            wr_start = trk_start_q[evict_idx];
            wr_end   = trk_nxt_q[evict_idx];
        end else if (exp_hit) begin
            wr_en = trk_count_q[exp_idx] >= MIN_RUN;
        end

        close_mask = '0;
        alloc_mask = '0;
        for (int i = 0; i < NUM_TRACKERS; i++) begin
            if (trk_act_q[i] && trk_ld_q[i] && ((trk_date_q[i] == 4'd0) || (ni && is_jalr_i)))
                close_mask[i] = 1'b1;
            if (!evict && exp_hit && (exp_idx == TRK_W'(i)))
                close_mask[i] = 1'b1;
            if (alloc && (sel_idx == TRK_W'(i)))
                alloc_mask[i] = 1'b1;
        end
        trk_act_d = (trk_act_q & ~close_mask) | alloc_mask;
        trk_ld_d  = (trk_ld_q & ~alloc_mask) | (alloc_mask & {NUM_TRACKERS{op_ld}});

        rgn_hit       = 1'b0;
        rgn_start_hit = 1'b0;
        for (int r = 0; r < REGION_DEPTH; r++) begin
            if (rgn_vld_q[r] && (rgn_start_q[r] <= addr) && (addr < rgn_end_q[r]))
                rgn_hit = 1'b1;
            if (rgn_vld_q[r] && (rgn_start_q[r] == addr))
                rgn_start_hit = 1'b1;
        end

        last_ptr = (wr_ptr_q == '0) ? PTR_W'(REGION_DEPTH - 1) : wr_ptr_q - PTR_W'(1);
`ifdef BOP_REGION_MERGE_EN
        merge_en = wr_en && (rgn_cnt_q != '0) && (wr_start == rgn_end_q[last_ptr]);
`else
        merge_en = 1'b0;
`endif
    end

    // Control state: reset and flush apply here
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            trk_act_q      <= '0;
            trk_ld_q       <= '0;
            rgn_vld_q      <= '0;
            wr_ptr_q       <= '0;
            rgn_cnt_q      <= '0;
            last_pc_q      <= '1;
            last_hit_vld_q <= 1'b0;
            region_wr_o    <= 1'b0;
            load_hit_o     <= 1'b0;
            chain_alarm_o  <= 1'b0;
            leak_alarm_o   <= 1'b0;
        end else begin
            if (ni)
                last_pc_q <= pc_i;
            if (clear_i) begin
                trk_act_q      <= '0;
                trk_ld_q       <= '0;
                rgn_vld_q      <= '0;
                wr_ptr_q       <= '0;
                rgn_cnt_q      <= '0;
                last_hit_vld_q <= 1'b0;
                region_wr_o    <= 1'b0;
                load_hit_o     <= 1'b0;
                chain_alarm_o  <= 1'b0;
                leak_alarm_o   <= 1'b0;
            end else begin
                trk_act_q   <= trk_act_d;
                trk_ld_q    <= trk_ld_d;
                region_wr_o <= wr_en;
                if (wr_en && !merge_en) begin
                    rgn_vld_q[wr_ptr_q] <= 1'b1;
                    wr_ptr_q  <= (wr_ptr_q == PTR_W'(REGION_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
                    rgn_cnt_q <= sat_inc(rgn_cnt_q);
                end
                if (ni && is_load_i) begin
                    load_hit_o     <= rgn_hit;
                    last_hit_vld_q <= rgn_hit;
                    if (rgn_hit && last_hit_vld_q && (rs1_i == last_hit_rd_q))
                        chain_alarm_o <= 1'b1;
                end
                if (ext && op_ld && rgn_start_hit)
                    leak_alarm_o <= 1'b1;
            end
        end
    end

    // Datapath state: contents are qualified by the valid/active bits above
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_TRACKERS; i++) begin
            if (alloc_mask[i]) begin
                trk_start_q[i] <= addr;
                trk_nxt_q[i]   <= addr + ADDR_W'(op_bytes);
                trk_count_q[i] <= 32'(op_bytes);
                trk_date_q[i]  <= TMO;
            end else if (ext && (match_idx == TRK_W'(i))) begin
                trk_nxt_q[i]   <= trk_nxt_q[i] + ADDR_W'(op_bytes);
                trk_count_q[i] <= sat_add(trk_count_q[i], op_bytes);
                trk_date_q[i]  <= TMO;
            end else if (ni && trk_act_q[i] && (trk_date_q[i] != 4'd0)) begin
                trk_date_q[i]  <= trk_date_q[i] - 4'd1;
            end
        end
        if (wr_en) begin
            if (merge_en) begin
                rgn_end_q[last_ptr] <= wr_end;
            end else begin
                rgn_start_q[wr_ptr_q] <= wr_start;
                rgn_end_q[wr_ptr_q]   <= wr_end;
            end
        end
        if (ni && is_load_i)
            last_hit_rd_q <= rd_i;
    end

    assign region_count_o = rgn_cnt_q;

endmodule

// File: tb/tb_bop_multi_tracker.sv
// Directed self-checking bench for bop_multi_tracker (default parameters).
module tb_bop_multi_tracker;

`ifdef BOP_REGION_MERGE_EN
    localparam int MRG = 1;
`else
    localparam int MRG = 0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni, en_i, instr_valid_i, is_load_i, is_store_i, is_jalr_i, clear_i;
    logic [31:0] pc_i, base_i, imm_i;
    logic [1:0]  size_i;
    logic [4:0]  rs1_i, rd_i;
    logic        region_wr_o, load_hit_o, chain_alarm_o, leak_alarm_o;
    logic [3:0]  region_count_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pc;

    always #5 clk_i = ~clk_i;

    bop_multi_tracker dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .instr_valid_i(instr_valid_i),
        .pc_i(pc_i), .is_load_i(is_load_i), .is_store_i(is_store_i), .is_jalr_i(is_jalr_i),
        .size_i(size_i), .base_i(base_i), .imm_i(imm_i), .rs1_i(rs1_i), .rd_i(rd_i),
        .clear_i(clear_i), .region_wr_o(region_wr_o), .load_hit_o(load_hit_o),
        .chain_alarm_o(chain_alarm_o), .leak_alarm_o(leak_alarm_o),
        .region_count_o(region_count_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic instr(input logic ld, input logic st, input logic jr, input logic [1:0] sz,
                         input logic [31:0] b, input logic [31:0] im,
                         input logic [4:0] rs1, input logic [4:0] rd);
        pc            = pc + 32'd4;
        pc_i          = pc;
        is_load_i     = ld;
        is_store_i    = st;
        is_jalr_i     = jr;
        size_i        = sz;
        base_i        = b;
        imm_i         = im;
        rs1_i         = rs1;
        rd_i          = rd;
        instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        is_load_i     = 1'b0;
        is_store_i    = 1'b0;
        is_jalr_i     = 1'b0;
    endtask

    task automatic nop(input int n);
        for (int k = 0; k < n; k++) instr(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    endtask

    task automatic sb(input logic [31:0] a);
        instr(1'b0, 1'b1, 1'b0, 2'd0, a, 32'h0, 5'd10, 5'd0);
    endtask

    task automatic sw(input logic [31:0] a, input logic [4:0] rs1);
        instr(1'b0, 1'b1, 1'b0, 2'd2, a, 32'h0, rs1, 5'd0);
    endtask

    task automatic lw(input logic [31:0] a, input logic [4:0] rs1, input logic [4:0] rd);
        instr(1'b1, 1'b0, 1'b0, 2'd2, a, 32'h0, rs1, rd);
    endtask

    task automatic lb(input logic [31:0] a);
        instr(1'b1, 1'b0, 1'b0, 2'd0, a, 32'h0, 5'd12, 5'd13);
    endtask

    task automatic jalr();
        instr(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 5'd1, 5'd0);
    endtask

    task automatic record_sw(input logic [31:0] a);
        sw(a, 5'd10);
        nop(11);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; en_i = 1'b1; instr_valid_i = 1'b0; clear_i = 1'b0;
        is_load_i = 1'b0; is_store_i = 1'b0; is_jalr_i = 1'b0; size_i = 2'd0;
        base_i = '0; imm_i = '0; rs1_i = '0; rd_i = '0; pc = 32'h100; pc_i = pc;
        repeat (3) tick();
        check_eq("rst_region_wr", region_wr_o, 0);
        check_eq("rst_load_hit", load_hit_o, 0);
        check_eq("rst_chain", chain_alarm_o, 0);
        check_eq("rst_leak", leak_alarm_o, 0);
        check_eq("rst_count", region_count_o, 0);
        rst_ni = 1'b1;
        tick();

        // Byte store run 0x1000..0x1007 via base+imm, then expiry
        for (int i = 0; i < 8; i++) instr(1'b0, 1'b1, 1'b0, 2'd0, 32'h1000, 32'(i), 5'd10, 5'd0);
        nop(10);
        check_eq("t1_wr_before", region_wr_o, 0);
        check_eq("t1_cnt_before", region_count_o, 0);
        nop(1);
        check_eq("t1_wr_pulse", region_wr_o, 1);
        check_eq("t1_cnt", region_count_o, 1);
        tick();
        check_eq("t1_wr_drop", region_wr_o, 0);

        // Hit and chained illegal load
        lw(32'h1004, 5'd10, 5'd5);
        check_eq("t2_hit1", load_hit_o, 1);
        check_eq("t2_chain_no", chain_alarm_o, 0);
        lw(32'h1000, 5'd5, 5'd6);
        check_eq("t2_hit2", load_hit_o, 1);
        check_eq("t2_chain", chain_alarm_o, 1);
        nop(1);
        check_eq("t2_chain_sticky", chain_alarm_o, 1);
        check_eq("t2_hit_held", load_hit_o, 1);
        lw(32'h0F00, 5'd10, 5'd7);
        check_eq("t2_miss", load_hit_o, 0);
        jalr();

        // Leak sweep into [0x2000,0x2010)
        for (int k = 0; k < 4; k++) sw(32'h2000 + 32'(4 * k), 5'd11);
        nop(11);
        check_eq("t3_cnt", region_count_o, 2);
        lb(32'h1FFC); lb(32'h1FFD); lb(32'h1FFE);
        jalr();
        lb(32'h2000);
        check_eq("t3_jalr_noleak", leak_alarm_o, 0);
        check_eq("t3_hit", load_hit_o, 1);
        jalr();
        lb(32'h1FFC); lb(32'h1FFD); lb(32'h1FFE); lb(32'h1FFF);
        check_eq("t3_leak_pre", leak_alarm_o, 0);
        instr(1'b1, 1'b0, 1'b0, 2'd0, 32'h2010, 32'hFFFF_FFF0, 5'd12, 5'd13);
        check_eq("t3_leak", leak_alarm_o, 1);
        jalr();

        // Interleaved word streams and eviction
        for (int k = 0; k < 4; k++) begin
            sw(32'h3000 + 32'(4 * k), 5'd14);
            sw(32'h4000 + 32'(4 * k), 5'd14);
        end
        check_eq("t4_cnt_pre", region_count_o, 2);
        sw(32'h5000, 5'd14);
        check_eq("t4_evict_wr", region_wr_o, 1);
        check_eq("t4_evict_cnt", region_count_o, 3);
        nop(9);
        check_eq("t4_wr_idle", region_wr_o, 0);
        nop(1);
        check_eq("t4_wr_b", region_wr_o, 1);
        check_eq("t4_cnt_b", region_count_o, 4);
        nop(1);
        check_eq("t4_cnt_c", region_count_o, 5);
        lw(32'h300C, 5'd10, 5'd1);
        check_eq("t4_hit_a", load_hit_o, 1);
        lw(32'h4010, 5'd10, 5'd1);
        check_eq("t4_end_excl", load_hit_o, 0);
        jalr();

        // Table wrap
        record_sw(32'h7000); record_sw(32'h7100); record_sw(32'h7200);
        check_eq("t5_full", region_count_o, 8);
        record_sw(32'h7300);
        check_eq("t5_sat", region_count_o, 8);
        lw(32'h1000, 5'd10, 5'd1);
        check_eq("t5_oldest_gone", load_hit_o, 0);
        lw(32'h7300, 5'd10, 5'd1);
        check_eq("t5_ninth_hit", load_hit_o, 1);
        lw(32'h200F, 5'd10, 5'd1);
        check_eq("t5_second_hit", load_hit_o, 1);
        jalr();

        // Flush
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check_eq("clr_cnt", region_count_o, 0);
        check_eq("clr_chain", chain_alarm_o, 0);
        check_eq("clr_leak", leak_alarm_o, 0);
        check_eq("clr_hit", load_hit_o, 0);
        lw(32'h2000, 5'd10, 5'd1);
        check_eq("clr_table_empty", load_hit_o, 0);
        jalr();

        // Adjacent regions
        sw(32'h6000, 5'd10); sw(32'h6004, 5'd10);
        nop(11);
        check_eq("mg_cnt1", region_count_o, 1);
        sw(32'h6008, 5'd10); sw(32'h600C, 5'd10);
        nop(11);
        check_eq("mg_wr", region_wr_o, 1);
        check_eq("mg_cnt2", region_count_o, 2 - MRG);
        lw(32'h600C, 5'd10, 5'd1);
        check_eq("mg_hit_hi", load_hit_o, 1);
        lw(32'h6004, 5'd10, 5'd1);
        check_eq("mg_hit_lo", load_hit_o, 1);
        jalr();

        // Stalled PC counted once
        pc = pc + 32'd4; pc_i = pc;
        is_store_i = 1'b1; size_i = 2'd0; base_i = 32'h8000; imm_i = 32'h0; rs1_i = 5'd10;
        instr_valid_i = 1'b1;
        repeat (5) tick();
        instr_valid_i = 1'b0; is_store_i = 1'b0;
        sb(32'h8001); sb(32'h8002); sb(32'h8003);
        nop(11);
        check_eq("st_cnt", region_count_o, 3 - MRG);
        lw(32'h8003, 5'd10, 5'd1);
        check_eq("st_hit_last", load_hit_o, 1);
        lw(32'h8004, 5'd10, 5'd1);
        check_eq("st_miss_end", load_hit_o, 0);
        jalr();

        // Run one byte short of the minimum, then an excluded base register
        sb(32'h9000); sb(32'h9001); sb(32'h9002);
        nop(11);
        check_eq("min_no_wr", region_wr_o, 0);
        check_eq("min_cnt", region_count_o, 3 - MRG);
        for (int k = 0; k < 4; k++) sw(32'hA000 + 32'(4 * k), 5'd2);
        nop(11);
        check_eq("excl_cnt", region_count_o, 3 - MRG);

        // Reset mid-run
        sb(32'hB000);
        lw(32'h8000, 5'd10, 5'd1);
        check_eq("mr_hit", load_hit_o, 1);
        rst_ni = 1'b0;
        tick();
        check_eq("mr_region_wr", region_wr_o, 0);
        check_eq("mr_load_hit", load_hit_o, 0);
        check_eq("mr_chain", chain_alarm_o, 0);
        check_eq("mr_leak", leak_alarm_o, 0);
        check_eq("mr_count", region_count_o, 0);
        rst_ni = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bop_multi_tracker.md
Name: bop_multi_tracker

Overview:
Parametrised successor to the single-stream heap-overflow/dataleak checker in the CVA6 execute stage. It tracks up to NUM_TRACKERS concurrent consecutive-access runs, stores or loads, of byte, half or word size. Closed store runs long enough to be overflows go into an internal circular region table. Later loads are checked against that table for in-range hits, chained illegal loads and leak-style sweeps into a recorded region.

Parameters:
ADDR_W, 32, address/PC width
NUM_TRACKERS, 2, concurrent run trackers (1..8)
REGION_DEPTH, 8, region table entries (power of 2)
TIMEOUT, 10, new-instruction count before an untouched run expires (fits 4 bits)
MIN_RUN_BYTES, 4, a store run is recorded only if its count is at least this value
EXCL_REG0, 2, rs1 index ignored for run tracking (sp)
EXCL_REG1, 8, rs1 index ignored for run tracking (fp)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
en_i  in  1  tracking enable
instr_valid_i  in  1  instruction fields valid
pc_i  in  ADDR_W  instruction PC
is_load_i / is_store_i / is_jalr_i  in  1 each  op class (one-hot or none)
size_i  in  2  0=byte 1=half 2=word; 3 treated as word
base_i / imm_i  in  ADDR_W each  operand_a and sign-extended immediate
rs1_i / rd_i  in  5 each  register indices
clear_i  in  1  synchronous flush of trackers, table and alarms
region_wr_o  out  1  one-cycle pulse: region recorded or merged
load_hit_o  out  1  registered: previous new load hit a region
chain_alarm_o  out  1  sticky: chained illegal load
leak_alarm_o  out  1  sticky: load sweep reached a region start
region_count_o  out  $clog2(REGION_DEPTH+1)  valid entries, saturating

Behaviour:
- Reset values: all outputs 0, trackers inactive, table empty, write pointer 0, last_pc_q all-ones, last_hit_valid_q 0. clear_i sets the same state except last_pc_q; it takes priority over all other updates.
- addr = base_i + imm_i, mod 2^ADDR_W. bytes = 1/2/4 from size_i.
- New instruction (ni) = instr_valid_i & en_i & (pc_i != last_pc_q). On ni, last_pc_q <= pc_i. Repeated PCs from stalls are ignored.
- Tracker fields: active, kind (ST/LD), start, nxt (expected next address), count[31:0], date[3:0].
- Store or load on ni with rs1_i not EXCL_REG0/1:
  - If it matches an active tracker of the same kind with nxt==addr (lowest index wins): nxt += bytes, count += bytes, date=TIMEOUT.
  - Otherwise allocate the lowest inactive tracker: start=addr, nxt=addr+bytes, count=bytes, date=TIMEOUT.
  - If no tracker is inactive, evict the one with the smallest date (ties: lowest index), close it, and reuse it.
- On each ni, every active tracker not extended or allocated decrements date if date>0.
- is_jalr_i on ni closes all LD trackers.
- Closing:
  - LD close has no table side effect.
  - ST close writes region [start, nxt) if count>=MIN_RUN_BYTES.
  - One table write per cycle. Eviction close has priority. Otherwise the lowest-index ST tracker with date==0 closes that cycle, with or without ni. Other expired trackers wait and close on following cycles.
  - Expired trackers cannot be extended and are not free until closed.
- Table: circular. An entry is written at wr_ptr, then wr_ptr+1 wraps. When full, the oldest entry is overwritten and region_count_o stays at REGION_DEPTH. region_wr_o pulses in the cycle after the write. The new entry is visible to lookups from the next cycle.
- Load check on ni with is_load_i (all rs1 values):
  - hit = any valid entry with start<=addr<end, using unsigned compares. load_hit_o <= hit, updated on every ni load and held otherwise.
  - If hit & last_hit_valid_q & rs1_i==last_hit_rd_q, set chain_alarm_o.
  - Then last_hit_rd_q<=rd_i and last_hit_valid_q<=hit.
- Leak: an LD extension whose addr equals the start of a valid entry sets leak_alarm_o. A fresh allocation at a region start does not.
- Address wrap: nxt wraps mod 2^ADDR_W. Count saturates at all-ones.
- Alarms clear only by reset or clear_i.

Optional Feature:
BOP_REGION_MERGE_EN. When defined, a recorded region whose start equals the end of the most recently written valid entry extends that entry's end instead. wr_ptr and the count do not change, and region_wr_o still pulses. When not defined, every recorded region takes a new entry.

Test Plan:
- SB stores to 0x1000..0x1007, then 10 non-store new PCs, then one more -> region [0x1000,0x1008) written; region_wr_o one pulse; region_count_o=1.
- Same setup, then LW at 0x1004 with rd=5, then LW with rs1=5 at 0x1000 -> load_hit_o=1 after each load; chain_alarm_o=1 after the second and stays high.
- Region [0x2000,0x2010) recorded, then LB sweep 0x1FFC..0x2000 -> leak_alarm_o=1 on the 0x2000 cycle; a JALR mid-sweep at 0x1FFE closes the run, so no alarm.
- Interleaved SW streams at 0x3000 and 0x4000 (4 words each), NUM_TRACKERS=2 -> both record; a third stream at 0x5000 evicts the older-date tracker and records it the same cycle.
- Nine qualifying regions with REGION_DEPTH=8 -> region_count_o=8; the first region no longer hits; the ninth does. Macro on with adjacent regions 0x6000..0x6008 and 0x6008..0x6010 -> one entry [0x6000,0x6010).
- Stall: same pc_i held 5 cycles with an SB -> counted once; rst_ni low mid-run -> all outputs 0 the next cycle.
